// File: rtl/mipi_pkg.sv
// Shared definitions for the MIPI packet sequencer: FSM state encoding,
// the HS leader byte, the short-packet data-type threshold and the fixed
// header/footer sizes.
package mipi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_HEADER,
    ST_PAYLOAD,
    ST_FOOTER,
    ST_EOP
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hB8;
  localparam logic [5:0] SHORT_DT_LIMIT    = 6'h10;  // DT below this is a short packet
  localparam int         HDR_BYTES         = 4;      // DI, WC_lo, WC_hi, ECC
  localparam int         FTR_BYTES         = 2;      // CRC16

  // Beats needed to carry a given number of bytes across the lanes.
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/mipi_hdr_capture.sv
// Assembles the 4-byte packet header as it arrives over one or more beats.
// The outputs show the stored bytes merged with the beat currently on the
// bus, so the sequencer can decode DI/WC during the last header beat.
module mipi_hdr_capture
  import mipi_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int DATA_WIDTH = 8 * LANES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  beat_en,
  input  logic [1:0]            beat_idx,
  input  logic [DATA_WIDTH-1:0] lane_data,
  output logic [7:0]            hdr_di,
  output logic [15:0]           hdr_wc
);

  logic [8*HDR_BYTES-1:0] hdr_q;
  logic [8*HDR_BYTES-1:0] hdr_now;

  // Overlay the current beat's lane bytes onto the bytes collected so far.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    hdr_now = hdr_q;
    if (beat_en) begin
      for (int l = 0; l < LANES; l++) begin
        if (int'(beat_idx) * LANES + l < HDR_BYTES)
          hdr_now[(int'(beat_idx) * LANES + l) * 8 +: 8] = lane_data[l * 8 +: 8];
      end
    end
  end

  // Header byte store; ECC lands in the top byte and is kept but not checked.
  // NOTE: this is a small register, not a RAM, so it is reset like any other
  // flop; that keeps the decoded fields at zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hdr_q <= '0;
    else if (beat_en) hdr_q <= hdr_now;
  end

  assign hdr_di = hdr_now[7:0];
  assign hdr_wc = hdr_now[23:8];

endmodule

// File: rtl/mipi_packet_sequencer.sv
// MIPI CSI-2 style packet sequencer: hunts for the HS leader, decodes the
// packet header, times payload and footer beats, and strobes end_of_packet
// so a downstream aligner can re-arm. Error strobes flag hunt failures and
// packets cut short by hs_valid dropping.
module mipi_packet_sequencer
  import mipi_pkg::*;
#(
  parameter int         LANES        = 2,
  parameter int         DATA_WIDTH   = 8 * LANES,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
  parameter int         HUNT_TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hs_valid,
  input  logic [DATA_WIDTH-1:0] mipi_data,
  output logic                  end_of_packet,
  output logic                  pkt_start,
  output logic [5:0]            data_type,
  output logic [1:0]            virtual_channel,
  output logic [15:0]           word_count,
  output logic                  payload_valid,
  output logic                  sync_err,
  output logic                  trunc_err
);

  localparam int HDR_BEATS = ceil_div(HDR_BYTES, LANES);
  localparam int FTR_BEATS = ceil_div(FTR_BYTES, LANES);
  localparam int HUNT_W    = $clog2(HUNT_TIMEOUT + 1);

  state_t              state_q, state_d;
  logic [HUNT_W-1:0]   hunt_cnt_q;
  logic [1:0]          beat_cnt_q;
  logic [15:0]         pay_cnt_q;
  logic                all_sync, any_sync;
  logic                hdr_en, hdr_last;
  logic                start_d, eop_d, serr_d, trunc_d;
  logic [7:0]          hdr_di;
  logic [15:0]         hdr_wc;
  logic [15:0]         pay_beats;

  mipi_hdr_capture #(
    .LANES      (LANES),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_hdr (
    .clk       (clk),
    .rst_n     (rst_n),
    .beat_en   (hdr_en),
    .beat_idx  (beat_cnt_q),
    .lane_data (mipi_data),
    .hdr_di    (hdr_di),
    .hdr_wc    (hdr_wc)
  );

  // Leader detection: every lane on SYNC_BYTE, or only some of them.
  always_comb begin
    all_sync = 1'b1;
    any_sync = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (mipi_data[l * 8 +: 8] == SYNC_BYTE) any_sync = 1'b1;
      else                                    all_sync = 1'b0;
    end
  end

  // Payload length in beats, rounded up to whole lane groups.
  assign pay_beats = 16'(({1'b0, hdr_wc} + 17'(LANES - 1)) / 17'(LANES));

  // Next-state and strobe decode. Losing hs_valid while hunting returns to
  // IDLE quietly: no packet was in flight, so there is nothing to report.
  always_comb begin
    state_d  = state_q;
    hdr_en   = 1'b0;
    hdr_last = 1'b0;
    start_d  = 1'b0;
    eop_d    = 1'b0;
    serr_d   = 1'b0;
    trunc_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (hs_valid) state_d = ST_SYNC;
      ST_SYNC: begin
        if (!hs_valid) state_d = ST_IDLE;
        else if (all_sync) state_d = ST_HEADER;
        else if (any_sync || hunt_cnt_q == HUNT_W'(HUNT_TIMEOUT - 1)) begin
          serr_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_HEADER: begin
        if (!hs_valid) begin
          trunc_d = 1'b1;
          eop_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          hdr_en = 1'b1;
          if (beat_cnt_q == 2'(HDR_BEATS - 1)) begin
            hdr_last = 1'b1;
            start_d  = 1'b1;
            if (hdr_di[5:0] < SHORT_DT_LIMIT) begin
              eop_d   = 1'b1;
              state_d = ST_EOP;
            end else if (hdr_wc == 16'd0) state_d = ST_FOOTER;
            else                          state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (!hs_valid) begin
          trunc_d = 1'b1;
          eop_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (pay_cnt_q == 16'd1) state_d = ST_FOOTER;
      end
      ST_FOOTER: begin
        if (!hs_valid) begin
          trunc_d = 1'b1;
          eop_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (beat_cnt_q == 2'(FTR_BEATS - 1)) begin
          eop_d   = 1'b1;
          state_d = ST_EOP;
        end
      end
      ST_EOP:  state_d = hs_valid ? ST_SYNC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and counters.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hunt_cnt_q <= '0;
      beat_cnt_q <= '0;
      pay_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      hunt_cnt_q <= (state_q == ST_SYNC && state_d == ST_SYNC) ? hunt_cnt_q + 1'b1 : '0;
      if (state_d != state_q) beat_cnt_q <= '0;
      else if (state_q == ST_HEADER || state_q == ST_FOOTER) beat_cnt_q <= beat_cnt_q + 1'b1;
      if (hdr_last) pay_cnt_q <= pay_beats;
      else if (state_q == ST_PAYLOAD && hs_valid) pay_cnt_q <= pay_cnt_q - 16'd1;
    end
  end

  // Registered strobes and header fields held until the next header.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_start       <= 1'b0;
      end_of_packet   <= 1'b0;
      sync_err        <= 1'b0;
      trunc_err       <= 1'b0;
      data_type       <= '0;
      virtual_channel <= '0;
      word_count      <= '0;
    end else begin
      pkt_start     <= start_d;
      end_of_packet <= eop_d;
      sync_err      <= serr_d;
      trunc_err     <= trunc_d;
      if (start_d) begin
        data_type       <= hdr_di[5:0];
        virtual_channel <= hdr_di[7:6];
        word_count      <= hdr_wc;
      end
    end
  end

  assign payload_valid = (state_q == ST_PAYLOAD) && hs_valid;

endmodule

// File: tb/tb_mipi_packet_sequencer.sv
// Self-checking bench for mipi_packet_sequencer (LANES=2). The driver builds
// packets at protocol level and pushes the expected events, stamped with the
// cycle they should appear in, onto per-kind queues; a negedge monitor pops
// and compares whenever the DUT raises a strobe.
module tb_mipi_packet_sequencer;

  localparam int LANES = 2;
  localparam int DW    = 8 * LANES;
  localparam int HT    = 1023;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hs_valid;
  logic [DW-1:0] mipi_data;
  logic          end_of_packet, pkt_start, payload_valid, sync_err, trunc_err;
  logic [5:0]    data_type;
  logic [1:0]    virtual_channel;
  logic [15:0]   word_count;

  mipi_packet_sequencer #(
    .LANES        (LANES),
    .DATA_WIDTH   (DW),
    .SYNC_BYTE    (8'hB8),
    .HUNT_TIMEOUT (HT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .hs_valid        (hs_valid),
    .mipi_data       (mipi_data),
    .end_of_packet   (end_of_packet),
    .pkt_start       (pkt_start),
    .data_type       (data_type),
    .virtual_channel (virtual_channel),
    .word_count      (word_count),
    .payload_valid   (payload_valid),
    .sync_err        (sync_err),
    .trunc_err       (trunc_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [5:0] dt; logic [1:0] vc; logic [15:0] wc; } start_t;
  typedef struct { int cyc; logic trunc; } eop_t;

  start_t q_start[$];
  eop_t   q_eop[$];
  int     q_pay[$];
  int     q_serr[$];

  int total = 0;
  int bad   = 0;

  // Protocol-level view of the receiver: hunting for a leader, or idle.
  bit hunting = 0;
  int hunt_n  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, {end_of_packet, pkt_start, data_type, virtual_channel, word_count,
                 payload_valid, sync_err, trunc_err}, '0);
  endtask

  function automatic logic [DW-1:0] no_sync_data();
    logic [DW-1:0] r;
    r = DW'($urandom);
    for (int l = 0; l < LANES; l++) if (r[l*8 +: 8] == 8'hB8) r[l*8 +: 8] = 8'h00;
    return r;
  endfunction

  function automatic logic [DW-1:0] partial_sync();
    logic [7:0] other;
    other = 8'($urandom);
    if (other == 8'hB8) other = 8'h00;
    return ($urandom_range(0, 1) == 1) ? {8'hB8, other} : {other, 8'hB8};
  endfunction

  task automatic drive(input logic v, input logic [DW-1:0] d);
    hs_valid  = v;
    mipi_data = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Beats carrying no leader. The first valid beat after idle only wakes the
  // receiver, so it carries a full leader that must be ignored.
  task automatic hunt_beats(input int n, input logic v);
    for (int k = 0; k < n; k++) begin
      if (!v) begin
        drive(1'b0, DW'($urandom));
        hunting = 0;
      end else if (!hunting) begin
        drive(1'b1, {LANES{8'hB8}});
        hunting = 1;
        hunt_n  = 0;
      end else begin
        hunt_n++;
        if (hunt_n == HT) begin
          q_serr.push_back(cyc + 1);
          hunting = 0;
        end
        drive(1'b1, no_sync_data());
      end
      step();
    end
  endtask

  task automatic sync_err_case(input logic [DW-1:0] d);
    if (!hunting) hunt_beats(1, 1'b1);
    q_serr.push_back(cyc + 1);
    drive(1'b1, d);
    step();
    hunting = 0;
  endtask

  // One packet. Body beats: 2 header, ceil(WC/LANES) payload (long only),
  // 1 CRC (long only). drop_at indexes a body beat where hs_valid drops (or
  // reset is applied when rst_drop); -1 means none. keep is hs_valid in EOP.
  task automatic send_packet(input logic [7:0] di, input logic [15:0] wc, input int drop_at,
                             input bit rst_drop, input logic keep, input int filler);
    int            npay, nbody;
    logic          short_pkt;
    logic [7:0]    ecc;
    logic [DW-1:0] d;
    start_t        s;
    eop_t          e;
    if (!hunting) hunt_beats(1, 1'b1);
    hunt_beats(filler, 1'b1);
    drive(1'b1, {LANES{8'hB8}});
    step();
    hunting   = 0;
    short_pkt = di[5:0] < 6'h10;
    npay      = short_pkt ? 0 : (int'(wc) + LANES - 1) / LANES;
    nbody     = 2 + npay + (short_pkt ? 0 : 1);
    ecc       = 8'($urandom);
    for (int i = 0; i < nbody; i++) begin
      if (i == 0)      d = {wc[7:0], di};
      else if (i == 1) d = {ecc, wc[15:8]};
      else             d = DW'($urandom);
      if (i == drop_at) begin
        if (rst_drop) begin
          rst_n = 1'b0;
          drive(1'b1, d);
          #1;
          check_zero("outputs_at_reset_assert");
          step();
          check_zero("outputs_during_reset");
          rst_n = 1'b1;
          drive(1'b0, '0);
        end else begin
          e.cyc   = cyc + 1;
          e.trunc = 1'b1;
          q_eop.push_back(e);
          drive(1'b0, d);
          step();
        end
        return;
      end
      if (i == 1) begin
        s.cyc = cyc + 1;
        s.dt  = di[5:0];
        s.vc  = di[7:6];
        s.wc  = wc;
        q_start.push_back(s);
      end
      if (i >= 2 && i < 2 + npay) q_pay.push_back(cyc);
      drive(1'b1, d);
      step();
    end
    e.cyc   = cyc;
    e.trunc = 1'b0;
    q_eop.push_back(e);
    drive(keep, DW'($urandom));
    step();
    hunting = keep;
    hunt_n  = 0;
  endtask

  // Monitor: every DUT strobe must match the oldest pending expectation.
  start_t            mon_s;
  eop_t              mon_e;
  int                mon_c;
  logic [23:0]       cur_hdr;
  always @(negedge clk) begin
    if (!rst_n) begin
      cur_hdr = '0;
    end else begin
      if (pkt_start) begin
        check("pkt_start_expected", q_start.size() > 0, 1);
        if (q_start.size() > 0) begin
          mon_s = q_start.pop_front();
          check("pkt_start_cycle", cyc, mon_s.cyc);
          check("data_type", data_type, mon_s.dt);
          check("virtual_channel", virtual_channel, mon_s.vc);
          check("word_count", word_count, mon_s.wc);
          cur_hdr = {mon_s.dt, mon_s.vc, mon_s.wc};
        end
      end
      if (payload_valid) begin
        check("payload_expected", q_pay.size() > 0, 1);
        if (q_pay.size() > 0) begin
          mon_c = q_pay.pop_front();
          check("payload_cycle", cyc, mon_c);
        end
      end
      if (end_of_packet) begin
        check("eop_expected", q_eop.size() > 0, 1);
        if (q_eop.size() > 0) begin
          mon_e = q_eop.pop_front();
          check("eop_cycle", cyc, mon_e.cyc);
          check("trunc_err_with_eop", trunc_err, mon_e.trunc);
        end
        check("fields_held_at_eop", {data_type, virtual_channel, word_count}, cur_hdr);
      end
      if (trunc_err) check("trunc_err_has_eop", end_of_packet, 1);
      if (sync_err) begin
        check("sync_err_expected", q_serr.size() > 0, 1);
        if (q_serr.size() > 0) begin
          mon_c = q_serr.pop_front();
          check("sync_err_cycle", cyc, mon_c);
        end
      end
      if (sync_err || trunc_err) check("serr_trunc_exclusive", sync_err & trunc_err, 0);
    end
  end

  initial begin
    rst_n     = 1'b0;
    hs_valid  = 1'b0;
    mipi_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst_n = 1'b1;
    step();

    // Long packet DI=2B WC=10: 5 payload beats, 1 CRC beat.
    send_packet(8'h2B, 16'd10, -1, 1'b0, 1'b0, 1);
    // Short packet DI=40: vc=1, dt=0, no payload.
    send_packet(8'h40, 16'h0123, -1, 1'b0, 1'b0, 0);
    // Partial leader, then a full hunt timeout.
    sync_err_case(16'h00B8);
    hunt_beats(1, 1'b1);
    while (hunting) hunt_beats(1, 1'b1);
    // hs_valid lost at payload beat 3 of WC=10.
    send_packet(8'h2B, 16'd10, 4, 1'b0, 1'b0, 0);
    // Back-to-back packets with hs_valid held through EOP.
    send_packet(8'h2B, 16'd10, -1, 1'b0, 1'b1, 0);
    send_packet(8'hEA, 16'd3, -1, 1'b0, 1'b1, 0);
    send_packet(8'h05, 16'h1234, -1, 1'b0, 1'b1, 0);
    send_packet(8'h12, 16'd0, -1, 1'b0, 1'b0, 0);
    // Reset in PAYLOAD, then valid beats with no leader must stay silent.
    send_packet(8'h2B, 16'd10, 4, 1'b1, 1'b0, 0);
    hunting = 0;
    hunt_beats(6, 1'b1);
    hunt_beats(1, 1'b0);

    // Randomized mix.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5:
          send_packet(8'($urandom), 16'($urandom_range(0, 12)), -1, 1'b0,
                      1'($urandom_range(0, 1)), $urandom_range(0, 2));
        6, 7:
          send_packet(8'($urandom), 16'($urandom_range(1, 12)), $urandom_range(0, 9), 1'b0,
                      1'($urandom_range(0, 1)), $urandom_range(0, 2));
        8: sync_err_case(partial_sync());
        default: hunt_beats($urandom_range(1, 4), 1'($urandom_range(0, 1)));
      endcase
    end

    hunt_beats(4, 1'b0);
    check("start_queue_drained", q_start.size(), 0);
    check("payload_queue_drained", q_pay.size(), 0);
    check("eop_queue_drained", q_eop.size(), 0);
    check("sync_err_queue_drained", q_serr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
